// File: rtl/match_sequencer.sv
// match_sequencer: game-flow controller for the Pong top level.
// Sequences the match through idle, serve, rally, goal pause, game over and
// user pause. It also owns both scores, the serve direction, the ball
// hold/run controls and the sound request strobes. All outputs are registered.
module match_sequencer #(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned PAUSE_FRAMES = 90,
  parameter int unsigned SCORE_W      = 4
) (
  input  logic               px_clk,
  input  logic               reset,
  input  logic               endframe,
  input  logic               play,
  input  logic               goal_ply1,
  input  logic               goal_ply2,
  output logic [2:0]         state,
  output logic               ball_hold,
  output logic               ball_run,
  output logic               serve,
  output logic               serve_dir,
  output logic               reset_goals,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         winner,
  output logic               snd_goal,
  output logic               snd_win
);

  localparam int unsigned MAX_FRAMES =
    (SERVE_FRAMES > PAUSE_FRAMES) ? SERVE_FRAMES : PAUSE_FRAMES;
  localparam int unsigned CNT_W = $clog2(MAX_FRAMES + 1);

  localparam logic [CNT_W-1:0]   SERVE_CNT = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0]   PAUSE_CNT = CNT_W'(PAUSE_FRAMES);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE      = 3'd1,
    RALLY      = 3'd2,
    GOAL_PAUSE = 3'd3,
    GAME_OVER  = 3'd4,
    PAUSED     = 3'd5
  } state_t;

  state_t             st;
  state_t             saved;
  logic               play_q;
  logic [CNT_W-1:0]   cnt;
  logic               play_edge;
  logic               cnt_last;
  logic [SCORE_W-1:0] score1_inc;
  logic [SCORE_W-1:0] score2_inc;

  assign play_edge  = play & ~play_q;
  assign cnt_last   = (cnt == CNT_ONE);
  assign score1_inc = score1 + SCORE_ONE;
  assign score2_inc = score2 + SCORE_ONE;
  assign state      = st;

  // Match FSM: state, counter, scores and every registered output.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      st          <= IDLE;
      saved       <= IDLE;
      play_q      <= 1'b0;
      cnt         <= '0;
      score1      <= '0;
      score2      <= '0;
      winner      <= 2'b00;
      serve_dir   <= 1'b0;
      ball_hold   <= 1'b1;
      ball_run    <= 1'b0;
      serve       <= 1'b0;
      reset_goals <= 1'b0;
      snd_goal    <= 1'b0;
      snd_win     <= 1'b0;
    end else begin
      play_q      <= play;
      serve       <= 1'b0;
      reset_goals <= 1'b0;
      snd_goal    <= 1'b0;
      snd_win     <= 1'b0;

      case (st)
        IDLE, GAME_OVER: begin
          if (play_edge) begin
            st          <= SERVE;
            score1      <= '0;
            score2      <= '0;
            winner      <= 2'b00;
            reset_goals <= 1'b1;
            cnt         <= SERVE_CNT;
            ball_hold   <= 1'b1;
            ball_run    <= 1'b0;
          end
        end

        SERVE: begin
          if (play_edge) begin
            saved <= SERVE;
            st    <= PAUSED;
          end else if (endframe) begin
            cnt <= cnt - CNT_ONE;
            if (cnt_last) begin
              st        <= RALLY;
              serve     <= 1'b1;
              ball_hold <= 1'b0;
              ball_run  <= 1'b1;
            end
          end
        end

        // player 1 wins a simultaneous-goal tie; player 2's pulse is dropped
        RALLY: begin
          if (play_edge) begin
            saved    <= RALLY;
            st       <= PAUSED;
            ball_run <= 1'b0;
          end else if (goal_ply1 || goal_ply2) begin
            snd_goal  <= 1'b1;
            ball_hold <= 1'b1;
            ball_run  <= 1'b0;
            if (goal_ply1) begin
              score1    <= score1_inc;
              serve_dir <= 1'b1;
              if (score1_inc == WIN_VAL) begin
                st      <= GAME_OVER;
                winner  <= 2'b01;
                snd_win <= 1'b1;
              end else begin
                st  <= GOAL_PAUSE;
                cnt <= PAUSE_CNT;
              end
            end else begin
              score2    <= score2_inc;
              serve_dir <= 1'b0;
              if (score2_inc == WIN_VAL) begin
                st      <= GAME_OVER;
                winner  <= 2'b10;
                snd_win <= 1'b1;
              end else begin
                st  <= GOAL_PAUSE;
                cnt <= PAUSE_CNT;
              end
            end
          end
        end

        GOAL_PAUSE: begin
          if (play_edge) begin
            saved <= GOAL_PAUSE;
            st    <= PAUSED;
          end else if (endframe) begin
            if (cnt_last) begin
              st  <= SERVE;
              cnt <= SERVE_CNT;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
        end

        // counter frozen and ball_hold untouched; resume restores motion
        PAUSED: begin
          if (play_edge) begin
            st       <= saved;
            ball_run <= (saved == RALLY);
          end
        end

        default: begin
          st        <= IDLE;
          ball_hold <= 1'b1;
          ball_run  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_sequencer.sv
// tb_match_sequencer: directed scoreboard bench for match_sequencer.
// Stimulus pushes the expected output snapshot for every output event
// (state change or pulse) and a negedge monitor pops and compares.
module tb_match_sequencer;

  logic       px_clk = 1'b0;
  logic       reset, endframe, play, goal_ply1, goal_ply2;
  logic [2:0] state;
  logic       ball_hold, ball_run, serve, serve_dir, reset_goals;
  logic [3:0] score1, score2;
  logic [1:0] winner;
  logic       snd_goal, snd_win;

  always #5 px_clk = ~px_clk;

  match_sequencer #(
    .WIN_SCORE   (3),
    .SERVE_FRAMES(3),
    .PAUSE_FRAMES(2),
    .SCORE_W     (4)
  ) dut (
    .px_clk     (px_clk),
    .reset      (reset),
    .endframe   (endframe),
    .play       (play),
    .goal_ply1  (goal_ply1),
    .goal_ply2  (goal_ply2),
    .state      (state),
    .ball_hold  (ball_hold),
    .ball_run   (ball_run),
    .serve      (serve),
    .serve_dir  (serve_dir),
    .reset_goals(reset_goals),
    .score1     (score1),
    .score2     (score2),
    .winner     (winner),
    .snd_goal   (snd_goal),
    .snd_win    (snd_win)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       hold;
    logic       run;
    logic       srv;
    logic       dir;
    logic       rg;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] win;
    logic       sg;
    logic       sw;
  } snap_t;

  snap_t exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  int    probe_cnt = 0;
  int    probe_seen = 0;
  bit    mon_en = 1'b0;
  logic [2:0] prev_st;
  snap_t cur, e;
  string nm;
  logic  ev;

  task automatic expect_ev(input string n, input logic [2:0] st,
                           input logic hold, input logic run, input logic srv,
                           input logic dir, input logic rg,
                           input logic [3:0] s1, input logic [3:0] s2,
                           input logic [1:0] win, input logic sg, input logic sw);
    snap_t x;
    x.st = st; x.hold = hold; x.run = run; x.srv = srv; x.dir = dir; x.rg = rg;
    x.s1 = s1; x.s2 = s2; x.win = win; x.sg = sg; x.sw = sw;
    exp_q.push_back(x);
    name_q.push_back(n);
  endtask

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  task automatic press();
    play = 1'b1; tick();
    play = 1'b0; tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      endframe = 1'b1; tick();
      endframe = 1'b0; tick();
    end
  endtask

  task automatic goal(input logic g1, input logic g2);
    goal_ply1 = g1; goal_ply2 = g2; tick();
    goal_ply1 = 1'b0; goal_ply2 = 1'b0; tick();
  endtask

  // Monitor: an output event is a state change, any pulse, or a probe request.
  always @(negedge px_clk) begin
    cur = '{state, ball_hold, ball_run, serve, serve_dir, reset_goals,
            score1, score2, winner, snd_goal, snd_win};
    ev = (probe_cnt != probe_seen) ||
         (mon_en && ((cur.st !== prev_st) || serve || reset_goals || snd_goal || snd_win));
    probe_seen = probe_cnt;
    prev_st = cur.st;
    if (ev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got %h exp none (t=%0t)", cur, $time);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (cur !== e) begin
          errors++;
          $display("FAIL %s got %h exp %h (t=%0t)", nm, cur, e, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; endframe = 1'b0; play = 1'b0; goal_ply1 = 1'b0; goal_ply2 = 1'b0;
    repeat (3) tick();
    expect_ev("reset_state", 3'd0, 1,0,0,0,0, 4'd0,4'd0, 2'b00, 0,0);
    probe_cnt++; tick();
    reset = 1'b0; mon_en = 1'b1;
    tick(); tick();

    // 1: start from IDLE, serve after 3 frames
    expect_ev("t1_start", 3'd1, 1,0,0,0,1, 4'd0,4'd0, 2'b00, 0,0);
    press();
    expect_ev("t1_serve", 3'd2, 0,1,1,0,0, 4'd0,4'd0, 2'b00, 0,0);
    frames(3);

    // 2: player 2 scores
    expect_ev("t2_goal", 3'd3, 1,0,0,0,0, 4'd0,4'd1, 2'b00, 1,0);
    goal(0, 1);
    expect_ev("t2_to_serve", 3'd1, 1,0,0,0,0, 4'd0,4'd1, 2'b00, 0,0);
    frames(2);
    expect_ev("t2_serve", 3'd2, 0,1,1,0,0, 4'd0,4'd1, 2'b00, 0,0);
    frames(3);

    // 3: simultaneous goals, player 1 wins the tie
    expect_ev("t3_both", 3'd3, 1,0,0,1,0, 4'd1,4'd1, 2'b00, 1,0);
    goal(1, 1);
    expect_ev("t3_to_serve", 3'd1, 1,0,0,1,0, 4'd1,4'd1, 2'b00, 0,0);
    frames(2);
    expect_ev("t3_serve", 3'd2, 0,1,1,1,0, 4'd1,4'd1, 2'b00, 0,0);
    frames(3);

    // 4: player 1 reaches WIN_SCORE
    expect_ev("t4_goal2", 3'd3, 1,0,0,1,0, 4'd2,4'd1, 2'b00, 1,0);
    goal(1, 0);
    expect_ev("t4_to_serve", 3'd1, 1,0,0,1,0, 4'd2,4'd1, 2'b00, 0,0);
    frames(2);
    expect_ev("t4_serve", 3'd2, 0,1,1,1,0, 4'd2,4'd1, 2'b00, 0,0);
    frames(3);
    expect_ev("t4_win", 3'd4, 1,0,0,1,0, 4'd3,4'd1, 2'b01, 1,1);
    goal(1, 0);
    goal(1, 0); goal(0, 1); frames(2);
    expect_ev("t4_held", 3'd4, 1,0,0,1,0, 4'd3,4'd1, 2'b01, 0,0);
    probe_cnt++; tick();
    expect_ev("t4_restart", 3'd1, 1,0,0,1,1, 4'd0,4'd0, 2'b00, 0,0);
    press();

    // 5: pause in SERVE with two frames left, then resume
    frames(1);
    expect_ev("t5_pause", 3'd5, 1,0,0,1,0, 4'd0,4'd0, 2'b00, 0,0);
    press();
    frames(10);
    expect_ev("t5_resume", 3'd1, 1,0,0,1,0, 4'd0,4'd0, 2'b00, 0,0);
    press();
    frames(1);
    expect_ev("t5_one_left", 3'd1, 1,0,0,1,0, 4'd0,4'd0, 2'b00, 0,0);
    probe_cnt++; tick();
    expect_ev("t5_serve", 3'd2, 0,1,1,1,0, 4'd0,4'd0, 2'b00, 0,0);
    frames(1);
    // pause in RALLY; the simultaneous goal is discarded
    expect_ev("t5_rally_pause", 3'd5, 0,0,0,1,0, 4'd0,4'd0, 2'b00, 0,0);
    play = 1'b1; goal_ply1 = 1'b1; tick();
    play = 1'b0; goal_ply1 = 1'b0; tick();
    goal(0, 1); frames(2);
    expect_ev("t5_rally_resume", 3'd2, 0,1,0,1,0, 4'd0,4'd0, 2'b00, 0,0);
    press();

    // 6: reach score1=2 in RALLY, then reset together with a goal
    expect_ev("t6_goal1", 3'd3, 1,0,0,1,0, 4'd1,4'd0, 2'b00, 1,0);
    goal(1, 0);
    expect_ev("t6_to_serve1", 3'd1, 1,0,0,1,0, 4'd1,4'd0, 2'b00, 0,0);
    frames(2);
    expect_ev("t6_serve1", 3'd2, 0,1,1,1,0, 4'd1,4'd0, 2'b00, 0,0);
    frames(3);
    expect_ev("t6_goal2", 3'd3, 1,0,0,1,0, 4'd2,4'd0, 2'b00, 1,0);
    goal(1, 0);
    expect_ev("t6_to_serve2", 3'd1, 1,0,0,1,0, 4'd2,4'd0, 2'b00, 0,0);
    frames(2);
    expect_ev("t6_serve2", 3'd2, 0,1,1,1,0, 4'd2,4'd0, 2'b00, 0,0);
    frames(3);
    expect_ev("t6_reset", 3'd0, 1,0,0,0,0, 4'd0,4'd0, 2'b00, 0,0);
    reset = 1'b1; goal_ply1 = 1'b1; tick();
    reset = 1'b0; goal_ply1 = 1'b0;
    repeat (4) tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
